// File: rtl/lane_pack_collector_if.sv
// ---------------------------------------------------------------------------
// lane_pack_collector_if
// Handshake bundle between a word producer, the lane packer and the
// downstream OR-reduction stage.
//   in_data   [WIDTH]          incoming word
//   in_valid                   in_data is valid
//   in_ready                   packer can accept a word
//   flush                      close the current partial array
//   out_arr   [LANES][WIDTH]   packed array, lane LANES-1 holds the first word
//   out_count [clog2(LANES+1)] number of lanes written in out_arr
//   out_valid                  out_arr / out_count are valid
//   out_ready                  downstream consumes the array
//   out_any                    OR of every bit of out_arr (0 when not built)
// Modports: slave = packer view, master = producer/consumer view.
// ---------------------------------------------------------------------------
interface lane_pack_collector_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 2
);
    localparam int unsigned CW = $clog2(LANES + 1);

    logic [WIDTH-1:0]            in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [LANES-1:0][WIDTH-1:0] out_arr;
    logic [CW-1:0]               out_count;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_any;

    modport slave (
        input  in_data,
        input  in_valid,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_arr,
        output out_count,
        output out_valid,
        output out_any
    );

    modport master (
        output in_data,
        output in_valid,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_arr,
        input  out_count,
        input  out_valid,
        input  out_any
    );
endinterface

// File: rtl/lane_pack_collector.sv
// ---------------------------------------------------------------------------
// lane_pack_collector
// Serial-to-parallel lane packer. Collects one WIDTH-bit word per accepted
// handshake into a LANES x WIDTH array (first word in the top lane), then
// presents the array plus a lane count on a valid/ready handshake. A flush
// closes a partially filled array with the unfilled lanes left at zero.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  lane_pack_collector_if.slave (see interface header for signals)
//
// Configuration macro: LANE_PACK_ANY_EN
//   defined   : out_any is a registered OR of the next out_arr value
//   undefined : out_any is tied to 0, no reduction logic is built
// ---------------------------------------------------------------------------
module lane_pack_collector #(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    lane_pack_collector_if.slave  bus
);
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [IW-1:0] IDX_TOP  = IW'(LANES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic                        r_in_ready;
    logic [LANES-1:0][WIDTH-1:0] r_arr;
    logic [CW-1:0]               r_count;
    logic                        r_valid;
    logic [IW-1:0]               r_idx;

    logic                        w_in_ready_nxt;
    logic [LANES-1:0][WIDTH-1:0] w_arr_nxt;
    logic [CW-1:0]               w_count_nxt;
    logic                        w_valid_nxt;
    logic [IW-1:0]               w_idx_nxt;

    logic                        w_accept;
    logic                        w_full;
    logic                        w_close;
    logic                        w_release;

    // Handshake qualifiers shared by the next-state and output logic.
    // r_in_ready is low in FILL only on the first cycle after reset.
    assign w_accept  = (r_state == S_FILL) && r_in_ready && bus.in_valid;
    assign w_full    = w_accept && (r_count == CNT_LAST);
    // Flush closes the array if it already holds a word or gains one now.
    assign w_close   = w_full ||
                       ((r_state == S_FILL) && bus.flush &&
                        (w_accept || (r_count != '0)));
    assign w_release = (r_state == S_HOLD) && r_valid && bus.out_ready;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FILL;
            r_in_ready <= 1'b0;
            r_arr      <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_idx      <= IDX_TOP;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_arr      <= w_arr_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= w_valid_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_close) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_release) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // Next values of the registered outputs and the lane index.
    always_comb begin
        w_arr_nxt   = r_arr;
        w_count_nxt = r_count;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_arr_nxt[r_idx] = bus.in_data;
                    w_count_nxt      = r_count + CW'(1);
                    // Index saturates at lane 0; the full case leaves FILL.
                    if (r_idx != '0) begin
                        w_idx_nxt = r_idx - IW'(1);
                    end
                end
                if (w_close) begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_release) begin
                    w_arr_nxt   = '0;
                    w_count_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_idx_nxt   = IDX_TOP;
                end
            end
            default: begin
                w_arr_nxt   = '0;
                w_count_nxt = '0;
                w_valid_nxt = 1'b0;
                w_idx_nxt   = IDX_TOP;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_FILL);
    end

`ifdef LANE_PACK_ANY_EN
    logic r_any;

    // Reduction of the next array so out_any lines up with out_arr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_arr_nxt;
        end
    end

    assign bus.out_any = r_any;
`else
    assign bus.out_any = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_arr   = r_arr;
    assign bus.out_count = r_count;
    assign bus.out_valid = r_valid;

endmodule
